// File: rtl/lb_pkg.sv
// Shared PicoBlaze port-bus constants and register-mode helpers for the lb_* blocks.
package lb_pkg;

  localparam int unsigned PB_PORT_W = 8;
  localparam int unsigned PB_DATA_W = 8;

  typedef logic [PB_PORT_W-1:0] port_id_t;

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_PULSE,
    MODE_STICKY
  } reg_mode_e;

  // Sticky takes priority over pulse when both mask bits are set.
  function automatic reg_mode_e reg_mode(input logic [15:0] pulse_mask,
                                         input logic [15:0] sticky_mask,
                                         input int unsigned idx);
    if (sticky_mask[idx])
      return MODE_STICKY;
    else if (pulse_mask[idx])
      return MODE_PULSE;
    else
      return MODE_NORMAL;
  endfunction

endpackage

// File: rtl/lb_sync2.sv
// Two-flop synchroniser, parametrised width, async active-high reset to 0.
module lb_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lb_port_regfile.sv
// Bank of PicoBlaze port-mapped registers (normal / pulse / sticky clear-on-read).
// Define LB_PORT_REGFILE_SYNC_EN to pass hw_set through a two-flop synchroniser.
module lb_port_regfile
  import lb_pkg::*;
#(
  parameter int unsigned          WIDTH       = 8,
  parameter int unsigned          NUM_REGS    = 4,
  parameter logic [7:0]           BASE_ADDR   = 8'h00,
  parameter logic [WIDTH-1:0]     RESET_VAL   = '1,
  parameter logic [NUM_REGS-1:0]  PULSE_MASK  = '0,
  parameter logic [NUM_REGS-1:0]  STICKY_MASK = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cs,
  input  logic [PB_PORT_W-1:0]      port_id,
  input  logic                      write_strobe,
  input  logic                      read_strobe,
  input  logic [WIDTH-1:0]          out_port,
  output logic [WIDTH-1:0]          in_port,
  output logic [NUM_REGS*WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*WIDTH-1:0] hw_set
);

  logic [NUM_REGS-1:0][WIDTH-1:0] q;
  logic [NUM_REGS-1:0][WIDTH-1:0] d;
  logic [NUM_REGS-1:0]            hit;
  logic [NUM_REGS-1:0]            wr;
  logic [NUM_REGS-1:0]            rd;
  logic [WIDTH-1:0]               rdata;
  logic [NUM_REGS*WIDTH-1:0]      set_bits;

`ifdef LB_PORT_REGFILE_SYNC_EN
  lb_sync2 #(
    .WIDTH (NUM_REGS*WIDTH)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (hw_set),
    .q     (set_bits)
  );
`else
  assign set_bits = hw_set;
`endif

  always_comb begin
    d     = q;
    hit   = '0;
    wr    = '0;
    rd    = '0;
    rdata = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      hit[i] = (port_id == port_id_t'(32'(BASE_ADDR) + i));
      wr[i]  = write_strobe && hit[i] && !cs;
      rd[i]  = read_strobe && hit[i] && !cs;
      case (reg_mode(16'(PULSE_MASK), 16'(STICKY_MASK), i))
        // set is OR-ed after the clear so a coincident hw_set survives the read
        MODE_STICKY: d[i] = (rd[i] ? '0 : q[i]) | set_bits[i*WIDTH +: WIDTH];
        MODE_PULSE:  d[i] = wr[i] ? out_port : '0;
        default:     d[i] = wr[i] ? out_port : q[i];
      endcase
      if (hit[i] && !cs)
        rdata = q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        q[i] <= (reg_mode(16'(PULSE_MASK), 16'(STICKY_MASK), i) == MODE_NORMAL) ? RESET_VAL : '0;
      in_port <= '0;
    end else begin
      q       <= d;
      in_port <= rdata;
    end
  end

  assign reg_q = q;

endmodule

// File: tb/tb_lb_port_regfile.sv
// Scoreboard bench for lb_port_regfile: stimulus queues expected values, a negedge monitor checks them.
module tb_lb_port_regfile;

`ifdef LB_PORT_REGFILE_SYNC_EN
  localparam int LAT  = 3;
  localparam int HOLD = 2;
`else
  localparam int LAT  = 1;
  localparam int HOLD = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b1;
  logic [7:0]  port_id = '0;
  logic        write_strobe = 1'b0;
  logic        read_strobe = 1'b0;
  logic [7:0]  out_port = '0;
  logic [7:0]  in_port;
  logic [31:0] reg_q;
  logic [31:0] hw_set = '0;

  typedef struct {
    int          cyc;
    bit          is_in;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  lb_port_regfile #(
    .WIDTH       (8),
    .NUM_REGS    (4),
    .BASE_ADDR   (8'h10),
    .RESET_VAL   (8'hFF),
    .PULSE_MASK  (4'b0010),
    .STICKY_MASK (4'b1000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cs           (cs),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .reg_q        (reg_q),
    .hw_set       (hw_set)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expectation due at or before the current cycle is checked mid-cycle.
  always @(negedge clk) begin
    logic [31:0] act;
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      act = e.is_in ? {24'h0, in_port} : reg_q;
      n_checks++;
      if (act !== e.exp) begin
        n_fails++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_q(input int dc, input logic [31:0] v, input string nm);
    sb.push_back('{cyc + dc, 1'b0, v, nm});
  endtask

  task automatic expect_in(input int dc, input logic [7:0] v, input string nm);
    sb.push_back('{cyc + dc, 1'b1, {24'h0, v}, nm});
  endtask

  initial begin
    // reset state: reg3 sticky=0, reg2 normal=FF, reg1 pulse=0, reg0 normal=FF
    tick();
    n_checks++;
    if (reg_q !== 32'h00FF_00FF) begin
      n_fails++;
      $display("FAIL direct_rst_regq: got %h expected %h", reg_q, 32'h00FF_00FF);
    end
    expect_q(0, 32'h00FF_00FF, "rst_regq");
    expect_in(0, 8'h00, "rst_inport");
    tick();
    reset = 1'b0;
    tick();

    // normal write then read
    cs = 1'b0; port_id = 8'h12; out_port = 8'hA5; write_strobe = 1'b1;
    expect_q(1, 32'h00A5_00FF, "wr_reg2");
    tick();
    n_checks++;
    if (reg_q !== 32'h00A5_00FF) begin
      n_fails++;
      $display("FAIL direct_wr_reg2: got %h expected %h", reg_q, 32'h00A5_00FF);
    end
    write_strobe = 1'b0; read_strobe = 1'b1;
    expect_in(1, 8'hA5, "rd_reg2");
    tick();
    n_checks++;
    if (in_port !== 8'hA5) begin
      n_fails++;
      $display("FAIL direct_rd_reg2: got %h expected %h", in_port, 8'hA5);
    end
    read_strobe = 1'b0;

    // chip select blocks writes and reads; unmapped address reads 0
    cs = 1'b1; out_port = 8'h11; write_strobe = 1'b1;
    expect_q(1, 32'h00A5_00FF, "wr_cs_blocked");
    tick();
    write_strobe = 1'b0; read_strobe = 1'b1;
    expect_in(1, 8'h00, "rd_cs_zero");
    tick();
    cs = 1'b0; port_id = 8'h20;
    expect_in(1, 8'h00, "rd_unmapped");
    tick();
    n_checks++;
    if (in_port !== 8'h00) begin
      n_fails++;
      $display("FAIL direct_rd_unmapped: got %h expected %h", in_port, 8'h00);
    end
    read_strobe = 1'b0;

    // pulse register: single and back-to-back writes
    port_id = 8'h11; out_port = 8'h3C; write_strobe = 1'b1;
    expect_q(1, 32'h00A5_3CFF, "pulse_hi");
    expect_q(2, 32'h00A5_00FF, "pulse_lo");
    tick();
    write_strobe = 1'b0;
    tick();
    tick();
    write_strobe = 1'b1;
    expect_q(1, 32'h00A5_3CFF, "pulse2_hi1");
    expect_q(2, 32'h00A5_3CFF, "pulse2_hi2");
    expect_q(3, 32'h00A5_00FF, "pulse2_lo");
    tick();
    tick();
    write_strobe = 1'b0;
    tick();
    tick();

    // sticky set, then clear-on-read
    port_id = 8'h13;
    hw_set = 32'h0500_0000;
    expect_q(LAT, 32'h05A5_00FF, "sticky_set");
    repeat (HOLD) tick();
    hw_set = '0;
    repeat (LAT + 2) tick();
    read_strobe = 1'b1;
    expect_in(1, 8'h05, "sticky_rd");
    expect_q(1, 32'h00A5_00FF, "sticky_clr");
    tick();
    read_strobe = 1'b0;
    tick();

    // sticky: hw_set bit 0 coincides with the clearing read, set wins
    hw_set = 32'h0500_0000;
    expect_q(LAT, 32'h05A5_00FF, "sticky_set2");
    repeat (HOLD) tick();
    hw_set = '0;
    repeat (LAT + 2) tick();
    hw_set = 32'h0100_0000;
    repeat (LAT - 1) tick();
    hw_set = (LAT == 1) ? 32'h0100_0000 : 32'h0;
    read_strobe = 1'b1;
    expect_in(1, 8'h05, "sticky_rd_pre");
    expect_q(1, 32'h01A5_00FF, "sticky_set_wins");
    tick();
    read_strobe = 1'b0; hw_set = '0;
    repeat (LAT + 1) tick();

    // sticky set is independent of cs
    cs = 1'b1;
    hw_set = 32'h8000_0000;
    expect_q(LAT, 32'h81A5_00FF, "sticky_set_cs1");
    repeat (HOLD) tick();
    hw_set = '0;
    repeat (LAT + 1) tick();
    cs = 1'b0;

    // async reset between two writes
    port_id = 8'h10; out_port = 8'h77; write_strobe = 1'b1;
    expect_q(1, 32'h81A5_0077, "wr_reg0");
    tick();
    write_strobe = 1'b0;
    tick();
    port_id = 8'h12; out_port = 8'h66; write_strobe = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (reg_q !== 32'h00FF_00FF) begin
      n_fails++;
      $display("FAIL direct_async_rst_regq: got %h expected %h", reg_q, 32'h00FF_00FF);
    end
    n_checks++;
    if (in_port !== 8'h00) begin
      n_fails++;
      $display("FAIL direct_async_rst_inport: got %h expected %h", in_port, 8'h00);
    end
    expect_q(0, 32'h00FF_00FF, "async_rst_regq");
    expect_in(0, 8'h00, "async_rst_inport");
    tick();
    reset = 1'b0; out_port = 8'h5A;
    expect_q(1, 32'h005A_00FF, "wr_after_rst");
    tick();
    n_checks++;
    if (reg_q !== 32'h005A_00FF) begin
      n_fails++;
      $display("FAIL direct_wr_after_rst: got %h expected %h", reg_q, 32'h005A_00FF);
    end
    write_strobe = 1'b0;

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fails++;
      $display("FAIL %s: got no check expected %h (timeout)", e.name, e.exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lb_port_regfile.md
# lb_port_regfile

Parametrised bank of PicoBlaze port-mapped registers. It generalises the single async-reset flip-flop to NUM_REGS words of WIDTH bits, each with a programmable reset value. Each word works in one of three modes: normal hold, self-clearing pulse, or sticky clear-on-read status. The bank sits on the processor's port_id / write_strobe / read_strobe bus and drives register contents to fabric logic and read data back to the CPU.

## Interface
- WIDTH, 8: bits per register (1..8, matches PicoBlaze data path)
- NUM_REGS, 4: register count (1..16)
- BASE_ADDR, 8'h00: port_id of register 0; register i at BASE_ADDR+i
- RESET_VAL, all ones: WIDTH-bit reset value applied to every normal-mode register
- PULSE_MASK, 0: NUM_REGS-bit vector; bit i=1 makes register i a self-clearing pulse register
- STICKY_MASK, 0: NUM_REGS-bit vector; bit i=1 makes register i a sticky status register (takes priority over PULSE_MASK)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  chip select, active-low; 1 blocks all CPU writes and clear-on-reads
- port_id  in  8  CPU port address
- write_strobe  in  1  CPU write qualifier, one cycle
- read_strobe  in  1  CPU read qualifier, one cycle
- out_port  in  WIDTH  CPU write data
- in_port  out  WIDTH  registered read data to CPU
- reg_q  out  NUM_REGS*WIDTH  register contents, register i at bits [i*WIDTH +: WIDTH]
- hw_set  in  NUM_REGS*WIDTH  per-bit set pulses for sticky registers; ignored for other modes

## Operation
- Address hit: hit_i = (port_id == BASE_ADDR+i). Addresses outside the window are unmapped.
- Normal register:
  - Loads out_port when write_strobe & hit_i & !cs.
  - Otherwise holds.
  - Reset value RESET_VAL.
- Pulse register:
  - Loads out_port on a qualified write.
  - Returns to 0 on the next clk edge unless another qualified write occurs.
  - Reset value 0.
- Sticky register:
  - Each bit is set by hw_set, whatever the state of cs.
  - All bits clear on read_strobe & hit_i & !cs.
  - CPU writes are ignored.
  - Reset value 0.
  - Simultaneous hw_set and clear-on-read on the same bit: set wins. The bit is 1 afterwards and the returned data shows the pre-read value.
- Read path:
  - in_port is loaded every clk edge with the contents of the register at port_id.
  - It loads 0 when port_id is unmapped or cs=1.
  - in_port reflects register state before any same-cycle update.
- write_strobe and read_strobe asserted together: the CPU never does this. The block applies each independently.

## Timing
- Write: reg_q changes on the clk edge that samples write_strobe. Latency 1 cycle. A pulse register holds the value for exactly 1 cycle.
- Read: in_port is valid 1 cycle after port_id is stable. This satisfies PicoBlaze INPUT timing, where port_id is held 2 cycles.
- Sticky set: the hw_set bit is visible in reg_q 1 cycle after the pulse (3 cycles with LB_PORT_REGFILE_SYNC_EN).
- Reset assertion:
  - Immediately forces normal registers to RESET_VAL, pulse and sticky registers to 0, and in_port to 0.
  - Is independent of clk.
  - A write in flight is lost.
- Reset release: the first write is accepted on the first clk edge after reset deasserts.

## Configuration
- LB_PORT_REGFILE_SYNC_EN defined:
  - Each hw_set bit passes through a two-flop synchroniser before the sticky logic. This supports asynchronous status sources.
  - Synchroniser flops reset to 0.
  - Sticky set latency becomes 3 cycles.
  - hw_set must be held at least 2 clk cycles to be captured.
- Undefined: hw_set is used directly. It must be synchronous to clk; a single-cycle pulse is captured.

## Structure
- Shared package lb_pkg holds:
  - PicoBlaze bus constants: port_id width 8, data width 8.
  - Register mode enumeration: MODE_NORMAL, MODE_PULSE, MODE_STICKY.
  - A function that derives register i's mode from PULSE_MASK/STICKY_MASK.
- Sub-module lb_sync2: two-flop synchroniser, parametrised width, async active-high reset. It is instantiated only under LB_PORT_REGFILE_SYNC_EN.

## Test plan
- Reset with defaults (WIDTH=8, NUM_REGS=4, BASE_ADDR=8'h10): reg_q = 32'hFFFF_FFFF, in_port = 0. With PULSE_MASK=4'b0010, the reg 1 slice = 0.
- Write 8'hA5 to port 8'h12, cs=0: reg 2 = 8'hA5 next cycle. Read port 8'h12: in_port = 8'hA5 one cycle later.
- Same write with cs=1: reg 2 unchanged. A read with cs=1 returns 0. A read of port 8'h20 returns 0.
- PULSE_MASK=4'b0010; write 8'h3C to 8'h11: reg 1 = 8'h3C for exactly 1 cycle, then 8'h00. Back-to-back writes hold it 2 cycles.
- STICKY_MASK=4'b1000:
  - hw_set reg 3 bits = 8'h05 for 1 cycle: reg 3 = 8'h05.
  - Read 8'h13: in_port = 8'h05 and reg 3 clears.
  - Repeat with hw_set bit 0 asserted during the read: reg 3 = 8'h01 afterwards.
- Assert reset mid-sequence, between two writes, asynchronously: all outputs return to their reset values before the next clk edge. Repeat the sticky test with LB_PORT_REGFILE_SYNC_EN: latency is 3 cycles, and a 1-cycle pulse is not guaranteed to be captured.
